// File: rtl/alu_serial_collector_pkg.sv
// ============================================================================
// alu_serial_collector_pkg
// Shared constants, collector state encoding and output word record.
// Revision: 1.0
// ============================================================================
`default_nettype none

package alu_serial_collector_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_ALU_LAT = 5;
    localparam int REC_LEN_W   = $clog2(DEF_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } coll_state_t;

    // Word record sized for the default width; narrower instances zero-extend into it.
    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic [REC_LEN_W-1:0] len;
        logic                 cout;
        logic                 ovf;
    } word_rec_t;

endpackage

`default_nettype wire

// File: rtl/alu_serial_collector_tag_delay.sv
// ============================================================================
// tag_delay
// Fixed-depth shift register carrying tags alongside the ALU pipeline.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tag_delay
    import alu_serial_collector_pkg::*;
#(
    parameter int DEPTH = DEF_ALU_LAT,
    parameter int W     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    logic [W-1:0] r_sr [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_sr[i] <= '0;
            end
        end else begin
            r_sr[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign dout = r_sr[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/alu_serial_collector.sv
// ============================================================================
// alu_serial_collector
// Realigns ALU tags, deserialises the LSB-first Sum stream, one-entry output buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module alu_serial_collector
    import alu_serial_collector_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int ALU_LAT = DEF_ALU_LAT
) (
    input  logic                         gclk,
    input  logic                         rst,
    input  logic                         bit_valid,
    input  logic                         bit_end,
    input  logic                         Sum,
    input  logic                         Carry_out,
    input  logic                         Overflow,
    input  logic                         word_ready,
    output logic                         word_valid,
    output logic [WIDTH-1:0]             word_data,
    output logic [$clog2(WIDTH+1)-1:0]   word_len,
    output logic                         word_cout,
    output logic                         word_ovf,
    output logic                         len_err,
    output logic                         overrun
);

    localparam int LEN_W = $clog2(WIDTH + 1);

    logic [1:0]       w_tag;
    logic             w_dv;
    logic             w_de;
    coll_state_t      r_state;
    coll_state_t      w_state_n;
    logic [LEN_W-1:0] r_idx;
    logic [WIDTH-1:0] r_asm;
    logic [WIDTH-1:0] w_word;
    logic             w_done;
    logic             w_len_err_set;
    logic             w_load;
    logic             r_valid;
    word_rec_t        r_buf;
    logic             r_len_err;
    logic             r_overrun;

    tag_delay #(
        .DEPTH (ALU_LAT),
        .W     (2)
    ) u_tag_delay (
        .clk  (gclk),
        .rst  (rst),
        .din  ({bit_valid, bit_end}),
        .dout (w_tag)
    );

    assign w_dv = w_tag[1];
    assign w_de = w_tag[0];

    always_ff @(posedge gclk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_comb begin
        w_state_n     = r_state;
        w_done        = 1'b0;
        w_len_err_set = 1'b0;
        // Assembly register is zero above idx, so OR-in gives the word including this bit.
        w_word        = r_asm | (WIDTH'(Sum) << r_idx);
        case (r_state)
            IDLE, COLLECT: begin
                if (w_dv) begin
                    if (w_de) begin
                        w_done    = 1'b1;
                        w_state_n = IDLE;
                    end else if (r_idx == LEN_W'(WIDTH - 1)) begin
                        w_len_err_set = 1'b1;
                        w_state_n     = DRAIN;
                    end else begin
                        w_state_n = COLLECT;
                    end
                end
            end
            DRAIN: begin
                if (w_dv && w_de) begin
                    w_state_n = IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge gclk) begin
        if (rst) begin
            r_idx <= '0;
            r_asm <= '0;
        end else if (w_state_n == IDLE) begin
            r_idx <= '0;
            r_asm <= '0;
        end else if (w_dv && r_state != DRAIN) begin
            r_asm <= w_word;
            r_idx <= r_idx + LEN_W'(1);
        end
    end

    // A completing word may reuse the slot being handed over in the same cycle.
    assign w_load = w_done && (!r_valid || word_ready);

    always_ff @(posedge gclk) begin
        if (rst) begin
            r_valid   <= 1'b0;
            r_buf     <= '0;
            r_len_err <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_valid    <= 1'b1;
                r_buf.data <= DEF_WIDTH'(w_word);
                r_buf.len  <= REC_LEN_W'(r_idx + LEN_W'(1));
                r_buf.cout <= Carry_out;
                r_buf.ovf  <= Overflow;
            end else if (word_ready) begin
                r_valid <= 1'b0;
            end
            if (w_done && !w_load) begin
                r_overrun <= 1'b1;
            end
            if (w_len_err_set) begin
                r_len_err <= 1'b1;
            end
        end
    end

    assign word_valid = r_valid;
    assign word_data  = WIDTH'(r_buf.data);
    assign word_len   = LEN_W'(r_buf.len);
    assign word_cout  = r_buf.cout;
    assign word_ovf   = r_buf.ovf;
    assign len_err    = r_len_err;
    assign overrun    = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_alu_serial_collector.sv
// ============================================================================
// tb_alu_serial_collector
// Randomised scoreboard bench with an ALU delay model and a word-level reference.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_alu_serial_collector;

    localparam int WIDTH = 8;
    localparam int LAT   = 5;
    localparam int LEN_W = $clog2(WIDTH + 1);

    logic             gclk = 1'b0;
    logic             rst = 1'b1;
    logic             bit_valid = 1'b0;
    logic             bit_end = 1'b0;
    logic             Sum = 1'b0;
    logic             Carry_out = 1'b0;
    logic             Overflow = 1'b0;
    logic             word_ready = 1'b0;
    logic             word_valid;
    logic [WIDTH-1:0] word_data;
    logic [LEN_W-1:0] word_len;
    logic             word_cout;
    logic             word_ovf;
    logic             len_err;
    logic             overrun;

    always #5 gclk = ~gclk;

    alu_serial_collector #(
        .WIDTH   (WIDTH),
        .ALU_LAT (LAT)
    ) dut (
        .gclk       (gclk),
        .rst        (rst),
        .bit_valid  (bit_valid),
        .bit_end    (bit_end),
        .Sum        (Sum),
        .Carry_out  (Carry_out),
        .Overflow   (Overflow),
        .word_ready (word_ready),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_len   (word_len),
        .word_cout  (word_cout),
        .word_ovf   (word_ovf),
        .len_err    (len_err),
        .overrun    (overrun)
    );

    typedef struct {
        logic [WIDTH-1:0] data;
        int               len;
        logic             cout;
        logic             ovf;
    } exp_t;

    exp_t             comp_at[int];     // word completions, keyed by the cycle the ALU result arrives
    bit               lenerr_at[int];
    logic             alu_s[int];
    logic             alu_c[int];
    logic             alu_o[int];
    exp_t             exp_q[$];
    exp_t             mon_e;
    bit               mdl_valid, mdl_len_err, mdl_overrun;
    bit               mon_en = 1'b0;
    bit               rand_rdy = 1'b0;
    bit               rdy_val = 1'b1;
    int               cyc = 0;
    int               n_pass = 0;
    int               n_total = 0;
    logic [WIDTH-1:0] trk_data = '0;
    int               trk_len = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Reference buffer behaviour for the cycle that just ended.
    task automatic model_update();
        int  drop[$];
        bit  hs;
        if (rst) begin
            mdl_valid   = 1'b0;
            mdl_len_err = 1'b0;
            mdl_overrun = 1'b0;
            exp_q.delete();
            foreach (comp_at[k]) if (k >= cyc) drop.push_back(k);
            foreach (drop[i]) comp_at.delete(drop[i]);
            drop.delete();
            foreach (lenerr_at[k]) if (k >= cyc) drop.push_back(k);
            foreach (drop[i]) lenerr_at.delete(drop[i]);
            return;
        end
        hs = mdl_valid && word_ready;
        if (comp_at.exists(cyc)) begin
            if (!mdl_valid || hs) begin
                exp_q.push_back(comp_at[cyc]);
                mdl_valid = 1'b1;
            end else begin
                mdl_overrun = 1'b1;
            end
            comp_at.delete(cyc);
        end else if (hs) begin
            mdl_valid = 1'b0;
        end
        if (lenerr_at.exists(cyc)) begin
            mdl_len_err = 1'b1;
            lenerr_at.delete(cyc);
        end
    endtask

    task automatic step(input bit bv, input bit be, input bit s, input bit co, input bit ov, input bit rs);
        @(posedge gclk);
        model_update();
        cyc++;
        #1;
        rst        = rs;
        bit_valid  = bv;
        bit_end    = be;
        word_ready = rand_rdy ? ($urandom_range(0, 9) < 7) : rdy_val;
        Sum        = alu_s.exists(cyc) ? alu_s[cyc] : 1'($urandom);
        Carry_out  = alu_c.exists(cyc) ? alu_c[cyc] : 1'($urandom);
        Overflow   = alu_o.exists(cyc) ? alu_o[cyc] : 1'($urandom);
        alu_s.delete(cyc);
        alu_c.delete(cyc);
        alu_o.delete(cyc);
        if (rs) begin
            trk_len  = 0;
            trk_data = '0;
        end else if (bv) begin
            alu_s[cyc+LAT] = s;
            alu_c[cyc+LAT] = co;
            alu_o[cyc+LAT] = ov;
            if (trk_len < WIDTH) trk_data[trk_len] = s;
            if (!be && trk_len == WIDTH - 1) lenerr_at[cyc+LAT] = 1'b1;
            trk_len++;
            if (be) begin
                if (trk_len <= WIDTH) comp_at[cyc+LAT] = '{trk_data, trk_len, co, ov};
                trk_len  = 0;
                trk_data = '0;
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    endtask

    task automatic send_word(input logic [15:0] bits, input int len, input bit co, input bit ov);
        for (int i = 0; i < len; i++) begin
            if (i == len - 1) step(1'b1, 1'b1, bits[i], co, ov, 1'b0);
            else step(1'b1, 1'b0, bits[i], 1'($urandom), 1'($urandom), 1'b0);
        end
    endtask

    task automatic check_reset(input string tag);
        @(negedge gclk);
        check({tag, "_rst_data"}, 32'(word_data), 32'h0);
        check({tag, "_rst_len"},  32'(word_len),  32'h0);
        check({tag, "_rst_cout"}, 32'(word_cout), 32'h0);
        check({tag, "_rst_ovf"},  32'(word_ovf),  32'h0);
        check({tag, "_rst_valid"}, 32'(word_valid), 32'h0);
        check({tag, "_rst_lenerr"}, 32'(len_err), 32'h0);
        check({tag, "_rst_overrun"}, 32'(overrun), 32'h0);
    endtask

    // Monitor: compares flags every cycle and pops the scoreboard on each handshake.
    always @(negedge gclk) begin
        if (mon_en) begin
            check("valid", 32'(word_valid), 32'(mdl_valid));
            check("len_err", 32'(len_err), 32'(mdl_len_err));
            check("overrun", 32'(overrun), 32'(mdl_overrun));
            if (word_valid === 1'b1 && word_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", 32'(word_data), 32'hFFFF_FFFF);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("word_data", 32'(word_data), 32'(mon_e.data));
                    check("word_len",  32'(word_len),  32'(mon_e.len));
                    check("word_cout", 32'(word_cout), 32'(mon_e.cout));
                    check("word_ovf",  32'(word_ovf),  32'(mon_e.ovf));
                end
            end
        end
    end

    initial begin
        logic [15:0] rbits;
        int          rlen;

        repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        mon_en = 1'b1;
        check_reset("init");

        // 8-bit 0xA5, carry set on the final bit
        send_word(16'h00A5, 8, 1'b1, 1'b0);
        idle(8);

        // 3-bit word, gap, then full-width all-ones
        send_word(16'h0003, 3, 1'b0, 1'b1);
        idle(2);
        send_word(16'h00FF, 8, 1'b0, 1'b0);
        idle(8);

        // Back-to-back words into a stalled buffer: second is dropped
        rdy_val = 1'b0;
        send_word(16'h0009, 4, 1'b0, 1'b0);
        send_word(16'h0006, 4, 1'b1, 1'b1);
        idle(10);
        rdy_val = 1'b1;
        idle(1);
        rdy_val = 1'b0;
        idle(4);
        rdy_val = 1'b1;
        idle(3);

        // Over-length word followed by a short word
        send_word(16'h02B5, 10, 1'b1, 1'b1);
        send_word(16'h0002, 2, 1'b1, 1'b0);
        idle(8);

        // Reset with bits in flight, then a clean word
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_reset("mid");
        send_word(16'h003C, 8, 1'b0, 1'b1);
        idle(8);

        // Completion coincides with the handshake of the buffered word
        rdy_val = 1'b0;
        send_word(16'h0001, 1, 1'b0, 1'b0);
        idle(2);
        send_word(16'h0000, 1, 1'b1, 1'b0);
        idle(4);
        rdy_val = 1'b1;
        idle(1);
        rdy_val = 1'b0;
        idle(1);
        @(negedge gclk);
        check("swap_valid", 32'(word_valid), 32'h1);
        check("swap_data", 32'(word_data), 32'h0);
        check("swap_cout", 32'(word_cout), 32'h1);
        check("swap_overrun", 32'(overrun), 32'h0);
        idle(2);
        rdy_val = 1'b1;
        idle(3);

        // Randomised traffic with random backpressure
        rand_rdy = 1'b1;
        repeat (300) begin
            rbits = 16'($urandom);
            rlen  = $urandom_range(1, 10);
            send_word(rbits, rlen, 1'($urandom), 1'($urandom));
            idle($urandom_range(0, 3));
        end
        rand_rdy = 1'b0;
        rdy_val  = 1'b1;
        idle(20);
        check("drain_empty", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/alu_serial_collector.md
# alu_serial_collector

Downstream deserializer for the bit-serial RSFQ ALU slice. It delays the bit-valid and word-end tags issued alongside the ALU operands by the ALU pipeline latency and collects the LSB-first `Sum` stream into a parallel word. On the final bit it captures `Carry_out` and `Overflow`, then presents the result through a one-entry valid/ready output buffer to the register-file write port.

## Interface
Parameters:
- `WIDTH`, 8: maximum word length in bits.
- `ALU_LAT`, 5: cycles from operand bits entering the ALU to `Sum`/`Carry_out`/`Overflow` appearing.

Ports:
- `gclk`  in  1: the single clock; all state updates on its rising edge.
- `rst`  in  1: reset, synchronous, active-high.
- `bit_valid`  in  1: high in each cycle a bit pair is driven into the ALU.
- `bit_end`  in  1: high with the last bit of a word, which is the ALU `End` input; ignored unless `bit_valid` is high.
- `Sum`  in  1: serial sum from the ALU.
- `Carry_out`  in  1: ALU carry.
- `Overflow`  in  1: ALU overflow.
- `word_ready`  in  1: consumer accepts the output word.
- `word_valid`  out  1: output buffer holds a word.
- `word_data`  out  WIDTH: collected word, bit 0 is the first bit received.
- `word_len`  out  $clog2(WIDTH+1): number of bits in the word (1..WIDTH).
- `word_cout`  out  1: `Carry_out` sampled with the final bit.
- `word_ovf`  out  1: `Overflow` sampled with the final bit.
- `len_err`  out  1: sticky; a word exceeded WIDTH bits.
- `overrun`  out  1: sticky; a completed word was dropped because the buffer was full.

## Operation
- Tag delay line: a shift register `ALU_LAT` deep carries {`bit_valid`, `bit_end`}. Its output pair is {`dv`, `de`} and is aligned with `Sum`.
- Collector states:
  - IDLE: `idx`=0, assembly register cleared.
  - COLLECT: when `dv`=1, write `Sum` into `asm[idx]` and increment `idx`.
  - DRAIN: entered on overflow of length; discard bits until `de`.
- Transitions:
  - IDLE/COLLECT with `dv` && !`de`: if `idx`==WIDTH-1, write the bit, set `len_err`, go to DRAIN. Otherwise go to or stay in COLLECT.
  - `dv` && `de` in IDLE/COLLECT: complete the word with length `idx`+1, sample `Carry_out` and `Overflow`, return to IDLE.
  - DRAIN with `dv` && `de`: go to IDLE. No word is emitted. `len_err` stays set.
- Bits above `word_len` in `word_data` are 0.
- Output buffer:
  - A completed word loads the buffer if the buffer is empty, or if `word_valid` && `word_ready` in the same cycle. In that case the buffer is handed over and reloaded, and `word_valid` stays 1.
  - Otherwise the new word is dropped, `overrun` is set, and the buffered word is kept unchanged.
  - `word_valid` && `word_ready` with no completion: `word_valid` goes to 0 next cycle.
- Cycles with `dv`=0 inside a word are gaps. State is held and `idx` is unchanged.

## Timing
- Reset values: `word_valid`=0, `word_data`=0, `word_len`=0, `word_cout`=0, `word_ovf`=0, `len_err`=0, `overrun`=0. The delay line, `idx` and state (IDLE) are also cleared.
- `rst` mid-word: the partial word and all in-flight tags are discarded. Bits already inside the ALU produce no output, because their tags were cleared.
- Latency: an end bit on `bit_end` at cycle t sets `word_valid` at cycle t+`ALU_LAT`+1.
- Throughput: back-to-back words with no idle cycle are supported. A 1-bit word completes in every cycle while `word_ready` is held high.
- Output fields are stable while `word_valid`=1 and !`word_ready`.
- The sticky flags clear only on `rst`.

## Structure
- Shared package holds:
  - the default `WIDTH` and `ALU_LAT` constants;
  - the collector state enum (IDLE, COLLECT, DRAIN);
  - a packed word-record typedef {data, len, cout, ovf}.
- One sub-module is natural: `tag_delay`, a parameterised depth-`ALU_LAT` shift register with synchronous reset. All other logic is flat.

## Test plan
- 8-bit word 0xA5, sent LSB first with `Carry_out`=1 and `Overflow`=0 on the last bit, `word_ready`=1 → `word_valid` one cycle at t_end+6, `word_data`=0xA5, `word_len`=8, `word_cout`=1, `word_ovf`=0.
- 3-bit word 1,1,0 followed by a gap, then an 8-bit word of all 1s, `word_ready`=1 → first output `word_data`=0x03 with `word_len`=3, second output `word_data`=0xFF with `word_len`=8.
- Two back-to-back 4-bit words, 0x9 then 0x6, with `word_ready`=0 → buffer holds 0x9, `overrun`=1. After `word_ready` pulses, `word_valid` drops and no 0x6 appears.
- 10-bit word with WIDTH=8, followed by a 2-bit word 0b10 → `len_err`=1, no output for the long word, next output `word_data`=0x02 with `word_len`=2.
- `rst` pulsed after 4 bits of an 8-bit word have entered the ALU → all outputs return to reset values. The next 8-bit word 0x3C is collected correctly with no stale bits.
- `word_ready` asserted in the same cycle a new word completes while `word_valid`=1 → old word is consumed, new word is loaded, `word_valid` stays 1, `overrun` stays 0.
